// File: rtl/ft1248_responder_if.sv
`default_nettype none
// ============================================================================
// Module   : ft1248_responder_if
// Brief    : FT1248 serial bus plus the local sink/source/modem-status side
//            of the responder, bundled with master and slave views.
// Revision : 1.0
// ============================================================================
interface ft1248_responder_if;
  logic       ft_clk;
  logic       ft_cs;
  logic       ft_miso;
  logic [7:0] ft_miosi_in;
  logic [7:0] ft_miosi_out;
  logic       ft_miosi_oe;
  logic       sink_full;
  logic       sink_write;
  logic [7:0] sink_wdata;
  logic       src_empty;
  logic       src_read;
  logic [7:0] src_rdata;
  logic [7:0] modem_status_in;
  logic [7:0] modem_status_out;
  logic       modem_status_wr;
  logic       flush_req;
  logic       nak_inject;

  modport slave (
    input  ft_clk, ft_cs, ft_miosi_in, sink_full, src_empty, src_rdata,
           modem_status_in, nak_inject,
    output ft_miso, ft_miosi_out, ft_miosi_oe, sink_write, sink_wdata,
           src_read, modem_status_out, modem_status_wr, flush_req
  );

  modport master (
    output ft_clk, ft_cs, ft_miosi_in, sink_full, src_empty, src_rdata,
           modem_status_in, nak_inject,
    input  ft_miso, ft_miosi_out, ft_miosi_oe, sink_write, sink_wdata,
           src_read, modem_status_out, modem_status_wr, flush_req
  );
endinterface
`default_nettype wire

// File: rtl/ft1248_responder.sv
`default_nettype none
// ============================================================================
// Module   : ft1248_responder
// Brief    : FT1248 slave oversampled on clk; optional NAK injection enabled
//            by defining FT1248_RESPONDER_NAK_INJECT_EN.
// Revision : 1.0
// ============================================================================
module ft1248_responder #(
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  ft1248_responder_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_COMMAND = 3'd1,
    S_STATUS  = 3'd2,
    S_DATA    = 3'd3,
    S_HOLD    = 3'd4
  } state_t;

  localparam logic [7:0] c_CMD_WRITE  = 8'h00;
  localparam logic [7:0] c_CMD_READ   = 8'h40;
  localparam logic [7:0] c_CMD_MS_RD  = 8'h20;
  localparam logic [7:0] c_CMD_MS_WR  = 8'h60;
  localparam logic [7:0] c_CMD_FLUSH  = 8'h08;

  logic [SYNC_STAGES-1:0] r_ftclk_sync;
  logic [SYNC_STAGES-1:0] r_cs_sync;
  logic [7:0]             r_dat_sync [SYNC_STAGES];
  logic                   r_ftclk_prev;
  logic                   r_cs_prev;

  // cs history resets low so a master already holding cs low is not mistaken
  // for a new frame; a real falling edge needs cs to be seen high first.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ftclk_sync <= '0;
      r_cs_sync    <= '0;
      r_ftclk_prev <= 1'b0;
      r_cs_prev    <= 1'b0;
      for (int i = 0; i < SYNC_STAGES; i++) r_dat_sync[i] <= '0;
    end else begin
      r_ftclk_sync[0] <= bus.ft_clk;
      r_cs_sync[0]    <= bus.ft_cs;
      r_dat_sync[0]   <= bus.ft_miosi_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_ftclk_sync[i] <= r_ftclk_sync[i-1];
        r_cs_sync[i]    <= r_cs_sync[i-1];
        r_dat_sync[i]   <= r_dat_sync[i-1];
      end
      r_ftclk_prev <= r_ftclk_sync[SYNC_STAGES-1];
      r_cs_prev    <= r_cs_sync[SYNC_STAGES-1];
    end
  end

  logic       w_clk_rise;
  logic       w_clk_fall;
  logic       w_cs_rise;
  logic       w_cs_fall;
  logic [7:0] w_dat;

  assign w_clk_rise =  r_ftclk_sync[SYNC_STAGES-1] & ~r_ftclk_prev;
  assign w_clk_fall = ~r_ftclk_sync[SYNC_STAGES-1] &  r_ftclk_prev;
  assign w_cs_rise  =  r_cs_sync[SYNC_STAGES-1]    & ~r_cs_prev;
  assign w_cs_fall  = ~r_cs_sync[SYNC_STAGES-1]    &  r_cs_prev;
  assign w_dat      =  r_dat_sync[SYNC_STAGES-1];

  logic w_nak_pending;
  logic w_nak_clear;

`ifdef FT1248_RESPONDER_NAK_INJECT_EN
  logic r_nak_latch;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_nak_latch <= 1'b0;
    end else if (bus.nak_inject) begin
      r_nak_latch <= 1'b1;
    end else if (w_nak_clear) begin
      r_nak_latch <= 1'b0;
    end
  end

  assign w_nak_pending = r_nak_latch;
`else
  logic w_unused_nak;
  assign w_nak_pending = 1'b0;
  assign w_unused_nak  = bus.nak_inject ^ w_nak_clear;
`endif

  state_t     r_state;
  logic [7:0] r_cmd;
  logic       r_first;
  logic       r_miso;
  logic       r_oe;
  logic [7:0] r_out;
  logic       r_sink_write;
  logic [7:0] r_sink_wdata;
  logic       r_src_read;
  logic [7:0] r_ms_out;
  logic       r_ms_wr;
  logic       r_flush;

  state_t     w_state_nxt;
  logic [7:0] w_cmd_nxt;
  logic       w_first_nxt;
  logic       w_miso_nxt;
  logic       w_oe_nxt;
  logic [7:0] w_out_nxt;
  logic       w_sink_write_nxt;
  logic [7:0] w_sink_wdata_nxt;
  logic       w_src_read_nxt;
  logic [7:0] w_ms_out_nxt;
  logic       w_ms_wr_nxt;
  logic       w_flush_nxt;
  logic       w_cmd_known;

  assign w_cmd_known = (r_cmd == c_CMD_WRITE) || (r_cmd == c_CMD_READ) ||
                       (r_cmd == c_CMD_MS_RD) || (r_cmd == c_CMD_MS_WR) ||
                       (r_cmd == c_CMD_FLUSH);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_cmd        <= '0;
      r_first      <= 1'b0;
      r_miso       <= 1'b1;
      r_oe         <= 1'b0;
      r_out        <= 8'hFF;
      r_sink_write <= 1'b0;
      r_sink_wdata <= '0;
      r_src_read   <= 1'b0;
      r_ms_out     <= 8'h00;
      r_ms_wr      <= 1'b0;
      r_flush      <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cmd        <= w_cmd_nxt;
      r_first      <= w_first_nxt;
      r_miso       <= w_miso_nxt;
      r_oe         <= w_oe_nxt;
      r_out        <= w_out_nxt;
      r_sink_write <= w_sink_write_nxt;
      r_sink_wdata <= w_sink_wdata_nxt;
      r_src_read   <= w_src_read_nxt;
      r_ms_out     <= w_ms_out_nxt;
      r_ms_wr      <= w_ms_wr_nxt;
      r_flush      <= w_flush_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_cmd_nxt        = r_cmd;
    w_first_nxt      = r_first;
    w_miso_nxt       = r_miso;
    w_oe_nxt         = r_oe;
    w_out_nxt        = r_out;
    w_sink_write_nxt = 1'b0;
    w_sink_wdata_nxt = r_sink_wdata;
    w_src_read_nxt   = 1'b0;
    w_ms_out_nxt     = r_ms_out;
    w_ms_wr_nxt      = 1'b0;
    w_flush_nxt      = 1'b0;
    w_nak_clear      = 1'b0;

    // End of frame wins over everything, so a byte sampled on the same edge is dropped.
    if (w_cs_rise) begin
      w_state_nxt = S_IDLE;
      w_miso_nxt  = 1'b1;
      w_oe_nxt    = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_miso_nxt = 1'b1;
          w_oe_nxt   = 1'b0;
          if (w_cs_fall) w_state_nxt = S_COMMAND;
        end

        S_COMMAND: begin
          if (w_clk_fall) begin
            w_cmd_nxt   = w_dat;
            w_state_nxt = S_STATUS;
          end
        end

        S_STATUS: begin
          if (w_clk_rise) begin
            w_miso_nxt  = ~(w_cmd_known & ~w_nak_pending);
            w_oe_nxt    = 1'b0;
            w_nak_clear = 1'b1;
          end
          if (w_clk_fall) begin
            w_state_nxt = r_miso ? S_HOLD : S_DATA;
            w_first_nxt = 1'b1;
          end
        end

        S_DATA: begin
          if (w_clk_rise) begin
            case (r_cmd)
              c_CMD_WRITE: begin
                w_miso_nxt = bus.sink_full;
                w_oe_nxt   = 1'b0;
              end
              c_CMD_READ: begin
                if (!bus.src_empty) begin
                  w_miso_nxt     = 1'b0;
                  w_oe_nxt       = 1'b1;
                  w_out_nxt      = bus.src_rdata;
                  w_src_read_nxt = 1'b1;
                end else begin
                  w_miso_nxt = 1'b1;
                  w_oe_nxt   = 1'b0;
                end
              end
              c_CMD_MS_RD: begin
                if (r_first) begin
                  w_miso_nxt = 1'b0;
                  w_oe_nxt   = 1'b1;
                  w_out_nxt  = bus.modem_status_in;
                end else begin
                  w_miso_nxt = 1'b1;
                  w_oe_nxt   = 1'b0;
                end
              end
              default: begin
                w_miso_nxt = ~r_first;
                w_oe_nxt   = 1'b0;
              end
            endcase
          end
          if (w_clk_fall) begin
            w_first_nxt = 1'b0;
            case (r_cmd)
              c_CMD_WRITE: begin
                if (!r_miso) begin
                  w_sink_write_nxt = 1'b1;
                  w_sink_wdata_nxt = w_dat;
                end
              end
              c_CMD_MS_WR: begin
                if (r_first) begin
                  w_ms_out_nxt = w_dat;
                  w_ms_wr_nxt  = 1'b1;
                end
              end
              c_CMD_FLUSH: begin
                if (r_first) w_flush_nxt = 1'b1;
              end
              default: ;
            endcase
          end
        end

        S_HOLD: begin
          w_miso_nxt = 1'b1;
          w_oe_nxt   = 1'b0;
        end

        default: begin
          w_state_nxt = S_IDLE;
          w_miso_nxt  = 1'b1;
          w_oe_nxt    = 1'b0;
        end
      endcase
    end
  end

  assign bus.ft_miso          = r_miso;
  assign bus.ft_miosi_out     = r_out;
  assign bus.ft_miosi_oe      = r_oe;
  assign bus.sink_write       = r_sink_write;
  assign bus.sink_wdata       = r_sink_wdata;
  assign bus.src_read         = r_src_read;
  assign bus.modem_status_out = r_ms_out;
  assign bus.modem_status_wr  = r_ms_wr;
  assign bus.flush_req        = r_flush;

endmodule
`default_nettype wire

// File: tb/tb_ft1248_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_ft1248_responder
// Brief    : Bench for ft1248_responder: command table plus hand sequences,
//            strobes checked against scoreboard queues.
// Revision : 1.0
// ============================================================================
module tb_ft1248_responder;

  localparam int SYNC = 2;
  localparam int HALF = SYNC + 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ft1248_responder_if bus ();

  ft1248_responder #(.SYNC_STAGES(SYNC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual %0h required %0h", name, act, exp);
  endtask

  logic [7:0] sink_q [$];
  logic [7:0] ms_q   [$];
  logic [7:0] src_fifo [$];
  int exp_src_reads  = 0;
  int seen_src_reads = 0;
  int exp_flush      = 0;
  int seen_flush     = 0;

  // Show-ahead source model
  always @(negedge clk) begin
    if (bus.src_read === 1'b1 && src_fifo.size() > 0) void'(src_fifo.pop_front());
    bus.src_empty = (src_fifo.size() == 0);
    bus.src_rdata = (src_fifo.size() > 0) ? src_fifo[0] : 8'h00;
  end

  always @(negedge clk) begin
    if (reset === 1'b0) begin
      int nstb;
      nstb = int'(bus.sink_write) + int'(bus.src_read) + int'(bus.modem_status_wr) + int'(bus.flush_req);
      if (nstb != 0) chk("strobe_exclusive", 32'(nstb), 32'd1);
      if (bus.sink_write) begin
        if (sink_q.size() == 0) begin
          n_checks++;
          $display("FAIL sink_write_unexpected: actual data %0h required no write", bus.sink_wdata);
        end else chk("sink_wdata", 32'(bus.sink_wdata), 32'(sink_q.pop_front()));
      end
      if (bus.modem_status_wr) begin
        if (ms_q.size() == 0) begin
          n_checks++;
          $display("FAIL ms_wr_unexpected: actual data %0h required no write", bus.modem_status_out);
        end else chk("modem_status_out", 32'(bus.modem_status_out), 32'(ms_q.pop_front()));
      end
      if (bus.src_read)  seen_src_reads++;
      if (bus.flush_req) seen_flush++;
    end
  end

  logic       t_st;
  logic       t_miso [4];
  logic       t_oe   [4];
  logic [7:0] t_dat  [4];

  task automatic ft_period(input logic [7:0] dout, output logic miso, output logic oe,
                           output logic [7:0] din);
    @(negedge clk);
    bus.ft_miosi_in = dout;
    bus.ft_clk      = 1'b1;
    repeat (HALF) @(negedge clk);
    miso = bus.ft_miso;
    oe   = bus.ft_miosi_oe;
    din  = bus.ft_miosi_out;
    bus.ft_clk = 1'b0;
    repeat (HALF - 1) @(negedge clk);
  endtask

  task automatic xfer(input logic [7:0] cmd, input int n, input logic [7:0] b0,
                      input logic [7:0] b1, input logic [7:0] b2);
    logic [7:0] wd [3];
    logic       dm, doe;
    logic [7:0] dd;
    wd[0] = b0; wd[1] = b1; wd[2] = b2;
    @(negedge clk);
    bus.ft_cs = 1'b0;
    repeat (HALF) @(negedge clk);
    ft_period(cmd, dm, doe, dd);
    ft_period(8'hFF, t_st, doe, dd);
    for (int i = 0; i < n; i++) ft_period(wd[i], t_miso[i], t_oe[i], t_dat[i]);
    @(negedge clk);
    bus.ft_cs = 1'b1;
    repeat (2 * HALF) @(negedge clk);
  endtask

  typedef struct {
    logic [7:0] cmd;
    logic [7:0] wbyte;
    logic       sink_full;
    logic       src_valid;
    logic [7:0] src_byte;
    logic [7:0] msin;
    logic       exp_st;
    logic       exp_dmiso;
    logic       exp_oe;
    logic [7:0] exp_rd;
  } vec_t;

  vec_t vecs [10];

  initial begin
    #500000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic dm, doe;
    logic [7:0] dd;

    vecs[0] = '{8'h00, 8'hC3, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00};
    vecs[1] = '{8'h00, 8'h3C, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00};
    vecs[2] = '{8'h40, 8'h00, 1'b0, 1'b1, 8'h7E, 8'h00, 1'b0, 1'b0, 1'b1, 8'h7E};
    vecs[3] = '{8'h40, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00};
    vecs[4] = '{8'h55, 8'h12, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00};
    vecs[5] = '{8'h08, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00};
    vecs[6] = '{8'h60, 8'h3C, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00};
    vecs[7] = '{8'h20, 8'h00, 1'b0, 1'b0, 8'h00, 8'h5A, 1'b0, 1'b0, 1'b1, 8'h5A};
    vecs[8] = '{8'hFF, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00};
    vecs[9] = '{8'h41, 8'h00, 1'b0, 1'b1, 8'h99, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00};

    bus.ft_clk          = 1'b0;
    bus.ft_cs           = 1'b1;
    bus.ft_miosi_in     = 8'h00;
    bus.sink_full       = 1'b0;
    bus.modem_status_in = 8'h00;
    bus.nak_inject      = 1'b0;
    reset = 1'b1;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    repeat (2 * HALF) @(negedge clk);

    chk("reset_miso",      32'(bus.ft_miso), 32'd1);
    chk("reset_oe",        32'(bus.ft_miosi_oe), 32'd0);
    chk("reset_out",       32'(bus.ft_miosi_out), 32'hFF);
    chk("reset_ms_out",    32'(bus.modem_status_out), 32'h00);
    chk("reset_strobes",   32'({bus.sink_write, bus.src_read, bus.modem_status_wr, bus.flush_req}), 32'd0);

    for (int v = 0; v < 10; v++) begin
      bus.sink_full       = vecs[v].sink_full;
      bus.modem_status_in = vecs[v].msin;
      if (vecs[v].src_valid) src_fifo.push_back(vecs[v].src_byte);
      if (vecs[v].cmd == 8'h00 && !vecs[v].sink_full) sink_q.push_back(vecs[v].wbyte);
      if (vecs[v].cmd == 8'h40 && vecs[v].src_valid) exp_src_reads++;
      if (vecs[v].cmd == 8'h60) ms_q.push_back(vecs[v].wbyte);
      if (vecs[v].cmd == 8'h08) exp_flush++;
      repeat (2) @(negedge clk);
      xfer(vecs[v].cmd, 1, vecs[v].wbyte, 8'h00, 8'h00);
      chk($sformatf("vec%0d_status", v), 32'(t_st), 32'(vecs[v].exp_st));
      chk($sformatf("vec%0d_dmiso", v),  32'(t_miso[0]), 32'(vecs[v].exp_dmiso));
      chk($sformatf("vec%0d_oe", v),     32'(t_oe[0]), 32'(vecs[v].exp_oe));
      if (vecs[v].exp_oe) chk($sformatf("vec%0d_rdata", v), 32'(t_dat[0]), 32'(vecs[v].exp_rd));
    end
    src_fifo.delete();
    bus.sink_full = 1'b0;

    // Two-byte write burst
    sink_q.push_back(8'hA5);
    sink_q.push_back(8'h5A);
    xfer(8'h00, 2, 8'hA5, 8'h5A, 8'h00);
    chk("wr2_status", 32'(t_st), 32'd0);
    chk("wr2_miso0",  32'(t_miso[0]), 32'd0);
    chk("wr2_miso1",  32'(t_miso[1]), 32'd0);

    // Read until source runs dry
    src_fifo.push_back(8'h11);
    src_fifo.push_back(8'h22);
    exp_src_reads += 2;
    repeat (2) @(negedge clk);
    xfer(8'h40, 3, 8'h00, 8'h00, 8'h00);
    chk("rd_status", 32'(t_st), 32'd0);
    chk("rd_data0",  32'(t_dat[0]), 32'h11);
    chk("rd_data1",  32'(t_dat[1]), 32'h22);
    chk("rd_miso0",  32'(t_miso[0]), 32'd0);
    chk("rd_miso1",  32'(t_miso[1]), 32'd0);
    chk("rd_miso2",  32'(t_miso[2]), 32'd1);
    chk("rd_oe2",    32'(t_oe[2]), 32'd0);

    // Modem status write then read
    ms_q.push_back(8'h20);
    xfer(8'h60, 2, 8'h20, 8'hEE, 8'h00);
    chk("msw_miso1", 32'(t_miso[1]), 32'd1);
    chk("msw_value", 32'(bus.modem_status_out), 32'h20);
    bus.modem_status_in = 8'h01;
    xfer(8'h20, 2, 8'h00, 8'h00, 8'h00);
    chk("msr_data",  32'(t_dat[0]), 32'h01);
    chk("msr_oe0",   32'(t_oe[0]), 32'd1);
    chk("msr_miso0", 32'(t_miso[0]), 32'd0);
    chk("msr_miso1", 32'(t_miso[1]), 32'd1);
    chk("msr_oe1",   32'(t_oe[1]), 32'd0);

    // Frame aborted in the middle of the second byte; its falling edge coincides with cs
    sink_q.push_back(8'hA5);
    @(negedge clk);
    bus.ft_cs = 1'b0;
    repeat (HALF) @(negedge clk);
    ft_period(8'h00, dm, doe, dd);
    ft_period(8'hFF, dm, doe, dd);
    ft_period(8'hA5, dm, doe, dd);
    @(negedge clk);
    bus.ft_miosi_in = 8'h5A;
    bus.ft_clk      = 1'b1;
    repeat (HALF) @(negedge clk);
    chk("abort_miso_before", 32'(bus.ft_miso), 32'd0);
    bus.ft_cs  = 1'b1;
    bus.ft_clk = 1'b0;
    repeat (SYNC + 1) @(negedge clk);
    chk("abort_miso_idle", 32'(bus.ft_miso), 32'd1);
    chk("abort_oe_idle",   32'(bus.ft_miosi_oe), 32'd0);
    repeat (2 * HALF) @(negedge clk);

    // NAK injection
    @(negedge clk);
    bus.nak_inject = 1'b1;
    @(negedge clk);
    bus.nak_inject = 1'b0;
`ifdef FT1248_RESPONDER_NAK_INJECT_EN
    xfer(8'h00, 1, 8'h66, 8'h00, 8'h00);
    chk("nak_status", 32'(t_st), 32'd1);
    chk("nak_dmiso",  32'(t_miso[0]), 32'd1);
    sink_q.push_back(8'h67);
    xfer(8'h00, 1, 8'h67, 8'h00, 8'h00);
    chk("nak_retry_status", 32'(t_st), 32'd0);
`else
    sink_q.push_back(8'h66);
    xfer(8'h00, 1, 8'h66, 8'h00, 8'h00);
    chk("nak_ignored_status", 32'(t_st), 32'd0);
`endif

    // Reset in mid-frame, then clocks while cs stays low
    @(negedge clk);
    bus.ft_cs = 1'b0;
    repeat (HALF) @(negedge clk);
    ft_period(8'h00, dm, doe, dd);
    ft_period(8'hFF, dm, doe, dd);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midrst_miso",   32'(bus.ft_miso), 32'd1);
    chk("midrst_out",    32'(bus.ft_miosi_out), 32'hFF);
    chk("midrst_ms_out", 32'(bus.modem_status_out), 32'h00);
    ft_period(8'h77, dm, doe, dd);
    chk("midrst_ignored_miso", 32'(dm), 32'd1);
    @(negedge clk);
    bus.ft_cs = 1'b1;
    repeat (2 * HALF) @(negedge clk);
    sink_q.push_back(8'h99);
    xfer(8'h00, 1, 8'h99, 8'h00, 8'h00);
    chk("midrst_recover_status", 32'(t_st), 32'd0);

    repeat (4) @(negedge clk);
    chk("src_read_count",   32'(seen_src_reads), 32'(exp_src_reads));
    chk("flush_count",      32'(seen_flush), 32'(exp_flush));
    chk("sink_q_drained",   32'(sink_q.size()), 32'd0);
    chk("ms_q_drained",     32'(ms_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ft1248_responder.md
FT1248_RESPONDER -- requirements
Module: ft1248_responder

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2: synchronizer depth on ft_clk, ft_cs and ft_miosi_in.
REQ-002 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port ft_clk  input  1  FT1248 serial clock from the master.
REQ-005 SHALL have port ft_cs  input  1  FT1248 chip select from the master, active-low.
REQ-006 SHALL have port ft_miso  output  1  status line: 0 = ACK, 1 = NAK or idle.
REQ-007 SHALL have port ft_miosi_in / ft_miosi_out / ft_miosi_oe  input / output / output  8 / 8 / 1  split bidirectional data bus.
REQ-008 SHALL have port sink_full / sink_write / sink_wdata  input / output / output  1 / 1 / 8  sink for bytes the master writes.
REQ-009 SHALL have port src_empty / src_read / src_rdata  input / output / input  1 / 1 / 8  source for bytes the master reads; show-ahead, so rdata is valid while src_empty is 0.
REQ-010 SHALL have port modem_status_in / modem_status_out / modem_status_wr  input / output / output  8 / 8 / 1  modem status returned to and written by the master.
REQ-011 SHALL have port flush_req  output  1  one-cycle pulse on write-buffer-flush.
REQ-012 SHALL have port nak_inject  input  1  forces the next status cycle to NAK (see Configuration).

Function
REQ-013 SHALL synchronize ft_clk, ft_cs and ft_miosi_in through SYNC_STAGES flops; edges are detected on the synchronized values.
REQ-014 SHALL operate correctly when the ft_clk high and low times are each at least SYNC_STAGES+1 clk cycles.
REQ-015 SHALL sample ft_miosi_in on a detected ft_clk falling edge and update ft_miso, ft_miosi_out and ft_miosi_oe one clk after a detected rising edge.
REQ-016 SHALL implement states IDLE, COMMAND, STATUS, DATA and HOLD.
REQ-017 IDLE -> COMMAND on synchronized ft_cs falling; COMMAND captures the command byte at the first falling edge, then -> STATUS.
REQ-018 STATUS rising edge: drive ft_miso=0 for 0x00, 0x40, 0x20, 0x60 and 0x08, and ft_miso=1 for any other command (-> HOLD after that falling edge).
REQ-019 ACKed commands -> DATA at the STATUS falling edge; each later ft_clk period is one byte.
REQ-020 0x00 (master write), each rising edge: ft_miso=sink_full; at the falling edge, if ft_miso=0, pulse sink_write for 1 cycle with the sampled byte; never set ft_miosi_oe.
REQ-021 0x40 (master read), each rising edge: if !src_empty, set ft_miosi_oe=1, ft_miosi_out=src_rdata, ft_miso=0 and pulse src_read for 1 cycle; else set ft_miso=1 and ft_miosi_oe=0.
REQ-022 0x20: first data rising edge drives modem_status_in with ft_miso=0; later cycles give ft_miso=1 and oe=0.
REQ-023 0x60: first data falling edge loads modem_status_out and pulses modem_status_wr; later cycles give ft_miso=1.
REQ-024 0x08: first data cycle gives ft_miso=0 and pulses flush_req at its falling edge; later cycles give ft_miso=1.
REQ-025 HOLD: ft_miso=1, oe=0, until ft_cs rises.
REQ-026 Synchronized ft_cs rising in any state -> IDLE the next clk, with ft_miso=1, ft_miosi_oe=0 and no strobe; a byte sampled at that edge is discarded.
REQ-027 sink_write, src_read, modem_status_wr and flush_req SHALL never assert together, and each SHALL pulse at most once per byte.

Reset
REQ-028 Reset SHALL force IDLE, ft_miso=1, ft_miosi_oe=0, ft_miosi_out=8'hFF, modem_status_out=8'h00, all strobes 0 and the nak_inject latch cleared.
REQ-029 Reset mid-transaction SHALL take effect on the next clk and ignore ft_clk until ft_cs is seen high.

Configuration
REQ-030 With FT1248_RESPONDER_NAK_INJECT_EN defined: nak_inject=1 sets a latch; the next STATUS cycle drives ft_miso=1 (-> HOLD) and clears the latch.
REQ-031 Without FT1248_RESPONDER_NAK_INJECT_EN: nak_inject SHALL be ignored, and no latch logic SHALL be synthesized.

Verification
REQ-032 Write 0x00 then bytes 0xA5,0x5A with sink not full -> ACK, two sink_write pulses carrying 0xA5 then 0x5A.
REQ-033 Read 0x40 with source holding 0x11,0x22, then empty -> data 0x11,0x22 with ft_miso=0, third cycle ft_miso=1, two src_read pulses.
REQ-034 0x60 with byte 0x20, then 0x20 with modem_status_in=0x01 -> modem_status_out=0x20, one modem_status_wr, read returns 0x01.
REQ-035 Command 0x55 -> ft_miso=1 in status, no strobes, oe stays 0.
REQ-036 Deassert ft_cs mid-write after one byte of a 3-byte burst -> IDLE within SYNC_STAGES+1 clk, exactly one sink_write pulse.
REQ-037 With NAK_INJECT_EN, pulse nak_inject then 0x00 -> status NAK, no sink_write; the retried 0x00 ACKs.
